// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter: video-first arbiter sharing one sync 8-bit RAM with CPU |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

  state_t        r_state, w_state_nxt;
  owner_t        r_owner, w_owner_nxt;
  logic          r_op_wr, w_op_wr_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;

  logic [15:0]   r_mem_addr, w_mem_addr_nxt;
  logic [7:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic          r_mem_wr, w_mem_wr_nxt;
  logic [7:0]    r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]    r_vid_rdata, w_vid_rdata_nxt;
  logic          r_cpu_ready, w_cpu_ready_nxt;
  logic          r_vid_ready, w_vid_ready_nxt;

  logic w_arb;
  logic w_cpu_done, w_vid_done;
  logic w_cpu_elig, w_vid_elig;
  logic w_starved;
  logic w_cpu_win, w_vid_win;

  // The completing owner's still-high req is the request being retired,
  // so it only counts again from the following arbitration edge.
  assign w_arb      = (r_state != S_ISSUE);
  assign w_cpu_done = (r_state == S_DATA) && (r_owner == OWN_CPU);
  assign w_vid_done = (r_state == S_DATA) && (r_owner == OWN_VID);
  assign w_cpu_elig = cpu_req && !w_cpu_done;
  assign w_vid_elig = vid_req && !w_vid_done;
  assign w_starved  = (r_starve == C_STARVE_MAX);
  assign w_cpu_win  = w_arb && w_cpu_elig && (!w_vid_elig || w_starved);
  assign w_vid_win  = w_arb && w_vid_elig && !w_cpu_win;

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_op_wr_nxt     = r_op_wr;
    w_starve_nxt    = r_starve;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wr_nxt    = r_mem_wr;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_vid_rdata_nxt = r_vid_rdata;
    w_cpu_ready_nxt = 1'b0;
    w_vid_ready_nxt = 1'b0;

    if (r_state == S_ISSUE) begin
      w_state_nxt  = S_DATA;
      w_mem_wr_nxt = 1'b0;
    end else begin
      if (w_cpu_done) begin
        w_cpu_ready_nxt = 1'b1;
        if (!r_op_wr) begin
          w_cpu_rdata_nxt = mem_rdata;
        end
      end
      if (w_vid_done) begin
        w_vid_ready_nxt = 1'b1;
        w_vid_rdata_nxt = mem_rdata;
      end

      if (w_cpu_win) begin
        w_state_nxt     = S_ISSUE;
        w_owner_nxt     = OWN_CPU;
        w_op_wr_nxt     = cpu_wr;
        w_mem_addr_nxt  = cpu_addr;
        w_mem_wdata_nxt = cpu_wdata;
        w_mem_wr_nxt    = cpu_wr;
      end else if (w_vid_win) begin
        w_state_nxt     = S_ISSUE;
        w_owner_nxt     = OWN_VID;
        w_op_wr_nxt     = 1'b0;
        w_mem_addr_nxt  = vid_addr;
        w_mem_wr_nxt    = 1'b0;
      end else begin
        w_state_nxt     = S_IDLE;
        w_owner_nxt     = OWN_NONE;
        w_op_wr_nxt     = 1'b0;
        w_mem_wr_nxt    = 1'b0;
      end

      if (w_cpu_win || !cpu_req) begin
        w_starve_nxt = '0;
      end else if (w_vid_win && w_cpu_elig && !w_starved) begin
        w_starve_nxt = r_starve + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_op_wr     <= 1'b0;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_vid_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_op_wr     <= w_op_wr_nxt;
      r_starve    <= w_starve_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_vid_rdata <= w_vid_rdata_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_vid_ready <= w_vid_ready_nxt;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr    = r_mem_wr;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign vid_rdata = r_vid_rdata;
  assign vid_ready = r_vid_ready;

endmodule
`default_nettype wire
